alu_seq: RTL and testbench

- Parametrised, registered successor of the team's 4-bit combinational ALU.
- Keeps the op/mode encoding (op[1:0], l select, cin) and the zero/carry/sign flags.
- Adds:
  - WIDTH-generic datapath
  - registered result and flag outputs
  - signed-overflow flag
  - start/busy/done handshake
  - multi-cycle unsigned shift-add multiply
- Sits between the register file and writeback in the Practica datapath.

---
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a multi-cycle unsigned shift-add multiply.
// Single-cycle logic/arithmetic results appear one edge after acceptance.
// A multiply holds busy high and finishes WIDTH edges later.
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             l,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             v,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       add_hi;
  logic                 is_mul;
  logic                 last_step;

  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c;
  logic                 alu_v;
  logic [WIDTH-1:0]     opnd_b;
  logic                 cin_eff;
  logic [WIDTH:0]       sum;

  assign is_mul    = (l == 1'b0) && (op == 2'b11);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == MUL);

  // Single-cycle logic/arithmetic result and flags from the live inputs.
  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    opnd_b  = '0;
    cin_eff = 1'b0;
    sum     = '0;
    if (l) begin
      case (op)
        2'b00:   alu_r = a & b;
        2'b01:   alu_r = a | b;
        2'b10:   alu_r = a ^ b;
        default: alu_r = ~a;
      endcase
    end else begin
      case (op)
        2'b00: begin
          opnd_b  = b;
          cin_eff = cin;
        end
        2'b01: begin
          opnd_b  = ~b;
          cin_eff = cin;
        end
        default: begin
          opnd_b  = {{(WIDTH-1){1'b0}}, 1'b1};
          cin_eff = 1'b0;
        end
      endcase
      sum   = {1'b0, a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, cin_eff};
      alu_r = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

  // One shift-add multiply step: conditional add into the upper half, then shift right.
  always_comb begin
    add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_step = {add_hi, acc[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: enter MUL on an accepted multiply, leave after the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_mul) state_nxt = MUL;
      MUL:     if (last_step)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand capture, multiply iteration and result/flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      r     <= '0;
      r_hi  <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      s     <= 1'b0;
      v     <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              cnt   <= '0;
              acc   <= {{WIDTH{1'b0}}, a};
              mcand <= b;
            end else begin
              r    <= alu_r;
              r_hi <= '0;
              z    <= (alu_r == '0);
              c    <= alu_c;
              s    <= alu_r[WIDTH-1];
              v    <= alu_v;
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            r    <= acc_step[WIDTH-1:0];
            r_hi <= acc_step[2*WIDTH-1:WIDTH];
            z    <= (acc_step == '0);
            c    <= |acc_step[2*WIDTH-1:WIDTH];
            s    <= acc_step[WIDTH-1];
            v    <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic model.
module tb_alu_seq;

  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int H = 1 << (W - 1);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic         l;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] r;
  logic [W-1:0] r_hi;
  logic         z;
  logic         c;
  logic         s;
  logic         v;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;

  // Last architecturally visible result (held between operations).
  int exp_r, exp_rhi, exp_z, exp_c, exp_s, exp_v;

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .l     (l),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .r     (r),
    .r_hi  (r_hi),
    .z     (z),
    .c     (c),
    .s     (s),
    .v     (v),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  // Reference: value-level meaning of each operation.
  task automatic model(input int il, input int iop, input int icin, input int ia, input int ib,
                       output int er, output int erhi, output int ec, output int ev);
    int u, sv, nb, p;
    er = 0; erhi = 0; ec = 0; ev = 0;
    if (il == 1) begin
      case (iop)
        0: er = ia & ib;
        1: er = ia | ib;
        2: er = ia ^ ib;
        default: er = (M - 1) - ia;
      endcase
    end else if (iop == 3) begin
      p    = ia * ib;
      er   = p % M;
      erhi = p / M;
      ec   = (erhi != 0) ? 1 : 0;
    end else begin
      if (iop == 0) begin
        u  = ia + ib + icin;
        sv = sx(ia) + sx(ib) + icin;
      end else if (iop == 1) begin
        nb = (M - 1) - ib;
        u  = ia + nb + icin;
        sv = sx(ia) + sx(nb) + icin;
      end else begin
        u  = ia + 1;
        sv = sx(ia) + 1;
      end
      er = u % M;
      ec = u / M;
      ev = (sv > H - 1 || sv < -H) ? 1 : 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".r"},    int'(r),    exp_r);
    check({tag, ".r_hi"}, int'(r_hi), exp_rhi);
    check({tag, ".z"},    int'(z),    exp_z);
    check({tag, ".c"},    int'(c),    exp_c);
    check({tag, ".s"},    int'(s),    exp_s);
    check({tag, ".v"},    int'(v),    exp_v);
  endtask

  // Issue one operation and follow it to completion.
  task automatic run_op(input int il, input int iop, input int icin, input int ia, input int ib,
                        input bit intrude);
    int er, erhi, ec, ev;
    model(il, iop, icin, ia, ib, er, erhi, ec, ev);
    @(negedge clk);
    l = il[0]; op = iop[1:0]; cin = icin[0]; a = ia[W-1:0]; b = ib[W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!(il == 0 && iop == 3)) begin
      exp_r = er; exp_rhi = 0; exp_c = ec; exp_v = ev;
      exp_z = (er == 0) ? 1 : 0;
      exp_s = (er >= H) ? 1 : 0;
      check("single.done", int'(done), 1);
      check("single.busy", int'(busy), 0);
      check_outputs("single");
    end else begin
      check("mul.busy0", int'(busy), 1);
      check("mul.done0", int'(done), 0);
      check("mul.hold_r0", int'(r), exp_r);
      for (int i = 1; i <= W; i++) begin
        if (intrude && i == 2) begin
          @(negedge clk);
          l = 1'b1; op = 2'b00; cin = 1'b0;
          a = W'($urandom); b = W'($urandom);
          start = 1'b1;
        end
        @(posedge clk); #1;
        if (i == W) begin
          start = 1'b0;
          exp_r = er; exp_rhi = erhi; exp_c = ec; exp_v = 0;
          exp_z = (er == 0 && erhi == 0) ? 1 : 0;
          exp_s = (er >= H) ? 1 : 0;
          check("mul.done", int'(done), 1);
          check("mul.busy_end", int'(busy), 0);
          check_outputs("mul");
        end else begin
          check("mul.busy", int'(busy), 1);
          check("mul.done_early", int'(done), 0);
          check("mul.hold_r", int'(r), exp_r);
          check("mul.hold_rhi", int'(r_hi), exp_rhi);
        end
      end
      // A start held through the final edge must not have been accepted.
      @(posedge clk); #1;
      check("mul.no_extra_done", int'(done), 0);
      check("mul.idle_busy", int'(busy), 0);
      check_outputs("mul_hold");
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, ".done_low"}, int'(done), 0);
    check({tag, ".busy_low"}, int'(busy), 0);
    check_outputs(tag);
  endtask

  task automatic zero_exp();
    exp_r = 0; exp_rhi = 0; exp_z = 0; exp_c = 0; exp_s = 0; exp_v = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    zero_exp();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; l = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("post_rst");

    // Directed cases.
    run_op(1, 2, 1, 15, 3, 1'b0);
    idle_check("xor_pulse");
    run_op(0, 0, 1, 15, 3, 1'b0);
    run_op(0, 1, 1, 3, 3, 1'b0);
    run_op(0, 0, 0, 7, 1, 1'b0);
    run_op(0, 2, 1, 7, 9, 1'b0);
    run_op(0, 3, 0, 15, 3, 1'b0);
    run_op(0, 3, 0, 0, 10, 1'b0);
    run_op(0, 3, 0, 15, 15, 1'b1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    l = 1'b0; op = 2'b11; a = 4'd13; b = 4'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    zero_exp();
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("abort_idle");
    run_op(0, 0, 0, 5, 6, 1'b0);

    // Randomized mix, including back-to-back single-cycle ops.
    for (int k = 0; k < 200; k++) begin
      run_op(int'($urandom_range(1, 0)), int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
             int'($urandom_range(M - 1, 0)), int'($urandom_range(M - 1, 0)),
             bit'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) == 0) idle_check("rand_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
